sprite_bounce: RTL and testbench

Parametrised bouncing-sprite offset generator for the VGA path: it moves a rectangular image window around the visible screen and bounces it off the edges. It sits between the VGA sync controller's pixel counters and the window/address logic, which consume the translated `fake_row`/`fake_column` coordinates. Compared with the fixed easter-egg mover, it adds:
- configurable geometry and step;
- a frame-rate divider;
- same-edge direction update;
- bounce and corner reporting.

---
 rtl/sprite_bounce_if.sv | 30 +++
 rtl/sprite_bounce.sv | 126 ++++++++++++
 tb/tb_sprite_bounce.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_bounce_if.sv
// Bundles the pixel-counter inputs, control inputs and sprite-offset outputs of sprite_bounce.
// The master drives pixel coordinates and control; the slave (the offset generator) answers.
interface sprite_bounce_if #(
  parameter int unsigned W = 10
);
  logic         enable;
  logic         recenter;
  logic [3:0]   frame_div;
  logic [W-1:0] pixel_row;
  logic [W-1:0] pixel_column;
  logic [W-1:0] fake_row;
  logic [W-1:0] fake_column;
  logic [W-1:0] offset_x;
  logic [W-1:0] offset_y;
  logic         dir_x;
  logic         dir_y;
  logic         bounce;
  logic         corner;
  logic [7:0]   bounce_count;

  modport master (
    output enable, recenter, frame_div, pixel_row, pixel_column,
    input  fake_row, fake_column, offset_x, offset_y, dir_x, dir_y, bounce, corner, bounce_count
  );

  modport slave (
    input  enable, recenter, frame_div, pixel_row, pixel_column,
    output fake_row, fake_column, offset_x, offset_y, dir_x, dir_y, bounce, corner, bounce_count
  );
endinterface

// File: rtl/sprite_bounce.sv
// Bouncing-sprite offset generator: moves an image window around the visible screen once every
// frame_div+1 frames, reflects it off the edges and reports bounces and corner hits.
module sprite_bounce #(
  parameter int unsigned W         = 10,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned SPRITE_W  = 256,
  parameter int unsigned SPRITE_H  = 384,
  parameter int unsigned STEP      = 1,
  parameter int unsigned INIT_X    = 191,
  parameter int unsigned INIT_Y    = 47,
  parameter int unsigned FRAME_ROW = 460,
  parameter int unsigned FRAME_COL = 620
) (
  input logic            clock,
  input logic            reset_n,
  sprite_bounce_if.slave bus
);
  localparam int unsigned LIMIT_X = SCREEN_W - SPRITE_W;
  localparam int unsigned LIMIT_Y = SCREEN_H - SPRITE_H;

  localparam logic [W-1:0] LimX     = W'(LIMIT_X);
  localparam logic [W-1:0] LimY     = W'(LIMIT_Y);
  localparam logic [W:0]   StepW    = (W+1)'(STEP);
  localparam logic [W-1:0] StepN    = W'(STEP);
  localparam logic [W-1:0] InitX    = W'(INIT_X);
  localparam logic [W-1:0] InitY    = W'(INIT_Y);
  localparam logic [W-1:0] FrameRow = W'(FRAME_ROW);
  localparam logic [W-1:0] FrameCol = W'(FRAME_COL);

  // One-axis move; bit W of the result flags a reversal. Compares are done one bit wider so a
  // position near 2^W cannot wrap before the edge test.
  function automatic logic [W:0] axis_next(input logic [W-1:0] pos, input logic dir,
                                           input logic [W-1:0] lim);
    logic [W:0] wide;
    wide = {1'b0, pos};
    if (dir) begin
      if (wide + StepW >= {1'b0, lim}) axis_next = {1'b1, lim};
      else                             axis_next = {1'b0, pos + StepN};
    end else begin
      if (wide <= StepW) axis_next = {1'b1, {W{1'b0}}};
      else               axis_next = {1'b0, pos - StepN};
    end
  endfunction

  logic [W-1:0] offset_x_q, offset_x_d, offset_y_q, offset_y_d;
  logic         dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [3:0]   div_cnt_q, div_cnt_d;
  logic         bounce_q, bounce_d, corner_q, corner_d;
  logic [7:0]   bounce_cnt_q, bounce_cnt_d;

  logic         frame_evt, step;
  logic [W:0]   nx, ny;
  logic         rev_x, rev_y;

  assign frame_evt = (bus.pixel_row == FrameRow) && (bus.pixel_column == FrameCol);
  assign step      = frame_evt && bus.enable && (div_cnt_q >= bus.frame_div);
  assign nx        = axis_next(offset_x_q, dir_x_q, LimX);
  assign ny        = axis_next(offset_y_q, dir_y_q, LimY);
  assign rev_x     = nx[W];
  assign rev_y     = ny[W];

  // Next state: recenter beats a step; bounce/corner default low so they pulse for one clock.
  always_comb begin
    offset_x_d   = offset_x_q;
    offset_y_d   = offset_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    div_cnt_d    = div_cnt_q;
    bounce_d     = 1'b0;
    corner_d     = 1'b0;
    bounce_cnt_d = bounce_cnt_q;
    if (bus.recenter) begin
      offset_x_d = InitX;
      offset_y_d = InitY;
      dir_x_d    = 1'b1;
      dir_y_d    = 1'b1;
      div_cnt_d  = 4'd0;
    end else if (step) begin
      offset_x_d   = nx[W-1:0];
      offset_y_d   = ny[W-1:0];
      dir_x_d      = dir_x_q ^ rev_x;
      dir_y_d      = dir_y_q ^ rev_y;
      div_cnt_d    = 4'd0;
      bounce_d     = rev_x | rev_y;
      corner_d     = rev_x & rev_y;
      bounce_cnt_d = bounce_cnt_q + 8'(rev_x | rev_y);
    end else if (frame_evt && bus.enable) begin
      div_cnt_d = div_cnt_q + 4'd1;
    end
  end

  // State registers with asynchronous reset to the initial position.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      offset_x_q   <= InitX;
      offset_y_q   <= InitY;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      div_cnt_q    <= 4'd0;
      bounce_q     <= 1'b0;
      corner_q     <= 1'b0;
      bounce_cnt_q <= 8'd0;
    end else begin
      offset_x_q   <= offset_x_d;
      offset_y_q   <= offset_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      div_cnt_q    <= div_cnt_d;
      bounce_q     <= bounce_d;
      corner_q     <= corner_d;
      bounce_cnt_q <= bounce_cnt_d;
    end
  end

  // Translated coordinates wrap modulo 2^W by construction.
  assign bus.fake_row     = bus.pixel_row - offset_y_q;
  assign bus.fake_column  = bus.pixel_column - offset_x_q;
  assign bus.offset_x     = offset_x_q;
  assign bus.offset_y     = offset_y_q;
  assign bus.dir_x        = dir_x_q;
  assign bus.dir_y        = dir_y_q;
  assign bus.bounce       = bounce_q;
  assign bus.corner       = corner_q;
  assign bus.bounce_count = bounce_cnt_q;
endmodule

// File: tb/tb_sprite_bounce.sv
// Scoreboard bench: three sprite_bounce instances (default, corner geometry, step-3 geometry)
// share one stimulus stream; a reference model pushes expected outputs, a monitor pops and checks.
module tb_sprite_bounce;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable, recenter;
  logic [3:0] frame_div;
  logic [9:0] row, col;

  always #5 clock = ~clock;

  sprite_bounce_if #(.W(10)) if_a ();
  sprite_bounce_if #(.W(10)) if_b ();
  sprite_bounce_if #(.W(10)) if_c ();

  assign if_a.enable = enable;  assign if_a.recenter = recenter;  assign if_a.frame_div = frame_div;
  assign if_a.pixel_row = row;  assign if_a.pixel_column = col;
  assign if_b.enable = enable;  assign if_b.recenter = recenter;  assign if_b.frame_div = frame_div;
  assign if_b.pixel_row = row;  assign if_b.pixel_column = col;
  assign if_c.enable = enable;  assign if_c.recenter = recenter;  assign if_c.frame_div = frame_div;
  assign if_c.pixel_row = row;  assign if_c.pixel_column = col;

  sprite_bounce #(.W(10)) dut_a (.clock(clock), .reset_n(reset_n), .bus(if_a));
  sprite_bounce #(.W(10), .INIT_X(383), .INIT_Y(95), .STEP(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(if_b));
  sprite_bounce #(.W(10), .INIT_X(382), .STEP(3), .SPRITE_H(383)) dut_c (
    .clock(clock), .reset_n(reset_n), .bus(if_c));

  // Geometry per instance: limits are screen minus sprite (640-256, 480-384, 480-383).
  int p_lx[3] = '{384, 384, 384};
  int p_ly[3] = '{96, 96, 97};
  int p_st[3] = '{1, 1, 3};
  int p_ix[3] = '{191, 383, 382};
  int p_iy[3] = '{47, 95, 47};

  typedef struct { int ox, oy, dx, dy, b, c, cnt, fr, fc; } obs_t;
  typedef struct { int id; obs_t o; } ent_t;
  ent_t q[$];

  int m_ox[3], m_oy[3], m_dx[3], m_dy[3], m_div[3], m_cnt[3];
  int n_chk = 0, n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic obs_t observe(int id);
    obs_t o;
    case (id)
      0: o = '{int'(if_a.offset_x), int'(if_a.offset_y), int'(if_a.dir_x), int'(if_a.dir_y),
               int'(if_a.bounce), int'(if_a.corner), int'(if_a.bounce_count),
               int'(if_a.fake_row), int'(if_a.fake_column)};
      1: o = '{int'(if_b.offset_x), int'(if_b.offset_y), int'(if_b.dir_x), int'(if_b.dir_y),
               int'(if_b.bounce), int'(if_b.corner), int'(if_b.bounce_count),
               int'(if_b.fake_row), int'(if_b.fake_column)};
      default: o = '{int'(if_c.offset_x), int'(if_c.offset_y), int'(if_c.dir_x),
                     int'(if_c.dir_y), int'(if_c.bounce), int'(if_c.corner),
                     int'(if_c.bounce_count), int'(if_c.fake_row), int'(if_c.fake_column)};
    endcase
    return o;
  endfunction

  task automatic cmp_obs(int id, obs_t a, obs_t e);
    chk($sformatf("dut%0d offset_x", id), a.ox, e.ox);
    chk($sformatf("dut%0d offset_y", id), a.oy, e.oy);
    chk($sformatf("dut%0d dir_x", id), a.dx, e.dx);
    chk($sformatf("dut%0d dir_y", id), a.dy, e.dy);
    chk($sformatf("dut%0d bounce", id), a.b, e.b);
    chk($sformatf("dut%0d corner", id), a.c, e.c);
    chk($sformatf("dut%0d bounce_count", id), a.cnt, e.cnt);
    chk($sformatf("dut%0d fake_row", id), a.fr, e.fr);
    chk($sformatf("dut%0d fake_column", id), a.fc, e.fc);
  endtask

  function automatic obs_t build(int id, int rx, int ry, int r, int c);
    obs_t o;
    o = '{m_ox[id], m_oy[id], m_dx[id], m_dy[id], rx | ry, rx & ry, m_cnt[id],
          (r - m_oy[id]) & 1023, (c - m_ox[id]) & 1023};
    return o;
  endfunction

  task automatic model_home(int id);
    m_ox[id] = p_ix[id]; m_oy[id] = p_iy[id];
    m_dx[id] = 1; m_dy[id] = 1; m_div[id] = 0;
  endtask

  // Move one axis by st towards dir; clamp at the wall and reverse when the wall is reached.
  task automatic move(inout int pos, inout int dir, input int lim, input int st, output int rev);
    int p;
    rev = 0;
    if (dir == 1) begin
      p = pos + st;
      if (p >= lim) begin p = lim; rev = 1; end
    end else begin
      p = pos - st;
      if (p <= 0) begin p = 0; rev = 1; end
    end
    if (rev == 1) dir = 1 - dir;
    pos = p;
  endtask

  task automatic model_cycle(int id, bit en, bit rc, int fd, int r, int c);
    int rx, ry;
    ent_t e;
    rx = 0; ry = 0;
    if (rc) model_home(id);
    else if (en && r == 460 && c == 620) begin
      if (m_div[id] >= fd) begin
        move(m_ox[id], m_dx[id], p_lx[id], p_st[id], rx);
        move(m_oy[id], m_dy[id], p_ly[id], p_st[id], ry);
        m_cnt[id] = (m_cnt[id] + (rx | ry)) % 256;
        m_div[id] = 0;
      end else m_div[id]++;
    end
    e.id = id;
    e.o  = build(id, rx, ry, r, c);
    q.push_back(e);
  endtask

  // Drive one clock's inputs at the falling edge and queue what each DUT should show after it.
  task automatic cycle(bit en, bit rc, int fd, bit fr);
    @(negedge clock);
    enable = en; recenter = rc; frame_div = 4'(fd);
    if (fr) begin row = 10'd460; col = 10'd620; end
    else begin row = 10'($urandom_range(0, 1023)); col = 10'($urandom_range(0, 1023)); end
    for (int i = 0; i < 3; i++) model_cycle(i, en, rc, fd, int'(row), int'(col));
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic reset_checks();
    for (int i = 0; i < 3; i++) begin
      model_home(i);
      m_cnt[i] = 0;
      cmp_obs(i, observe(i), build(i, 0, 0, int'(row), int'(col)));
    end
  endtask

  // Mid-frame asynchronous reset, away from any clock edge.
  task automatic do_reset();
    @(posedge clock);
    #3;
    enable = 1'b0; recenter = 1'b0; row = 10'd100; col = 10'd300;
    reset_n = 1'b0;
    #1;
    reset_checks();
    chk("reset fake_row", int'(if_a.fake_row), 53);
    chk("reset fake_column", int'(if_a.fake_column), 109);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Monitor: every output the DUTs present after an edge is matched against the queue.
  initial begin : monitor
    ent_t e;
    forever begin
      @(posedge clock);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp_obs(e.id, observe(e.id), e.o);
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int fd;
    reset_n = 1'b1; enable = 1'b0; recenter = 1'b0; frame_div = 4'd0; row = '0; col = '0;
    #1 reset_n = 1'b0;
    #2 reset_checks();
    @(negedge clock);
    reset_n = 1'b1;

    // First step: corner on dut_b, right-edge bounce on dut_c.
    cycle(1, 0, 0, 1);
    settle();
    chk("b corner", int'(if_b.corner), 1);
    chk("b corner offset_x", int'(if_b.offset_x), 384);
    chk("b corner offset_y", int'(if_b.offset_y), 96);
    chk("b corner dirs", int'({if_b.dir_x, if_b.dir_y}), 0);
    chk("c edge offset_x", int'(if_c.offset_x), 384);
    chk("c edge bounce", int'(if_c.bounce), 1);
    chk("c edge bounce_count", int'(if_c.bounce_count), 1);
    cycle(1, 0, 0, 0);
    settle();
    chk("c bounce one clock", int'(if_c.bounce), 0);
    cycle(1, 0, 0, 1);
    settle();
    chk("c after bounce offset_x", int'(if_c.offset_x), 381);

    do_reset();

    // Divider: frame_div=2 over nine frames steps three times.
    for (int i = 0; i < 9; i++) begin
      cycle(1, 0, 2, 1);
      cycle(1, 0, 2, 0);
    end
    settle();
    chk("divider offset_x", int'(if_a.offset_x), 194);
    chk("divider offset_y", int'(if_a.offset_y), 50);
    for (int i = 0; i < 3; i++) cycle(0, 0, 2, 1);
    settle();
    chk("disabled offset_x", int'(if_a.offset_x), 194);
    chk("disabled offset_y", int'(if_a.offset_y), 50);

    // Randomised run long enough to bounce every axis of every instance several times.
    fd = 0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 199) == 0)
        fd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1);
      if (i == 4000) do_reset();
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 2999) == 0, fd,
            $urandom_range(0, 1) == 1);
    end

    // Recenter coinciding with a step: recenter wins, count is kept.
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 1);
    settle();
    chk("recenter offset_x", int'(if_a.offset_x), 191);
    chk("recenter offset_y", int'(if_a.offset_y), 47);
    chk("recenter bounce", int'(if_c.bounce), 0);
    chk("recenter bounce_count kept", int'(if_c.bounce_count), m_cnt[2]);

    repeat (2) @(posedge clock);
    #2;
    chk("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
